// File: rtl/md_sequencer.sv
// MD_SEQUENCER: multi-cycle HI/LO multiply/divide sequencer for a MIPS-style pipeline.
// Operands are captured when an operation is issued. The result is written to HI/LO
// when the configured busy latency has elapsed. Stall tells the pipeline to hold while
// an md instruction waits in D.
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWr,
  input  logic        LOWr,
  input  logic        MDReq,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_prod;
  logic        w_aNeg;
  logic        w_bNeg;
  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic [31:0] w_bSafe;
  logic [31:0] w_qMag;
  logic [31:0] w_rMag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_divZero;
  logic        w_busy;

  // Result datapath from latched operands; division works on magnitudes so the
  // most-negative / -1 case wraps naturally to 0x80000000 with a zero remainder.
  always_comb begin
    w_prod    = 64'd0;
    w_aNeg    = r_signed & r_a[31];
    w_bNeg    = r_signed & r_b[31];
    w_aMag    = w_aNeg ? (~r_a + 32'd1) : r_a;
    w_bMag    = w_bNeg ? (~r_b + 32'd1) : r_b;
    w_divZero = (r_b == 32'd0);
    w_bSafe   = w_divZero ? 32'd1 : w_bMag;
    w_qMag    = w_aMag / w_bSafe;
    w_rMag    = w_aMag % w_bSafe;
    w_quot    = (w_aNeg ^ w_bNeg) ? (~w_qMag + 32'd1) : w_qMag;
    w_rem     = w_aNeg ? (~w_rMag + 32'd1) : w_rMag;
    if (r_signed) begin
      w_prod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    end else begin
      w_prod = {32'd0, r_a} * {32'd0, r_b};
    end
  end

  // Sequencer FSM: issue and latch, count down, commit; idle-time mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_signed <= op[0];
            r_cnt    <= op[1] ? DIV_LOAD : MUL_LOAD;
            r_state  <= op[1] ? DIV : MUL;
          end else begin
            if (HIWr) r_hi <= A;
            if (LOWr) r_lo <= A;
          end
        end
        MUL: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= IDLE;
          end
        end
        DIV: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!w_divZero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy = (r_state != IDLE);
  assign Busy   = w_busy;
  assign Stall  = MDReq & (start | (w_busy & ~reset));
  assign HI     = r_hi;
  assign LO     = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer. It runs table vectors for the arithmetic cases, hand
// sequences for the multi-cycle corner cases, and a random run compared against an
// operation-level model.
module tb_md_sequencer;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWr;
  logic        LOWr;
  logic        MDReq;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int compared = 0;
  int mismatched = 0;

  // Operation-level model state: cycles left busy, architectural HI/LO, pending result.
  int          mLeft = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] pHi = 32'd0;
  logic [31:0] pLo = 32'd0;
  bit          pValid = 1'b0;

  typedef struct {
    logic [1:0]  vOp;
    logic [31:0] vA;
    logic [31:0] vB;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          cycles;
  } vec_t;

  vec_t vecs[8];

  md_sequencer #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .HIWr(HIWr), .LOWr(LOWr), .MDReq(MDReq), .Busy(Busy), .Stall(Stall),
    .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model one rising edge using the inputs that are currently applied.
  function automatic void modelEdge();
    logic [63:0] prod;
    longint qa;
    longint qb;
    if (reset) begin
      mLeft = 0; mHi = 32'd0; mLo = 32'd0; pValid = 1'b0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && pValid) begin mHi = pHi; mLo = pLo; end
    end else if (start) begin
      pValid = 1'b1;
      case (op)
        2'b00: begin prod = 64'(A) * 64'(B); pHi = prod[63:32]; pLo = prod[31:0]; end
        2'b01: begin
          prod = 64'(longint'($signed(A)) * longint'($signed(B)));
          pHi = prod[63:32]; pLo = prod[31:0];
        end
        2'b10: begin
          if (B == 32'd0) pValid = 1'b0;
          else begin pLo = A / B; pHi = A % B; end
        end
        default: begin
          if (B == 32'd0) pValid = 1'b0;
          else begin
            qa = longint'($signed(A)); qb = longint'($signed(B));
            pLo = 32'(qa / qb); pHi = 32'(qa % qb);
          end
        end
      endcase
      mLeft = op[1] ? DIVN : MULN;
    end else begin
      if (HIWr) mHi = A;
      if (LOWr) mLo = A;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " Busy"}, 32'(Busy), 32'(mLeft > 0));
    checkOutput({tag, " HI"}, HI, mHi);
    checkOutput({tag, " LO"}, LO, mLo);
  endtask

  task automatic checkStall(input string tag);
    logic expS;
    #1;
    expS = MDReq & (start | ((mLeft > 0) & ~reset));
    checkOutput({tag, " Stall"}, 32'(Stall), 32'(expS));
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    HIWr = 1'b0; LOWr = 1'b0; MDReq = 1'b0;

    vecs[0] = '{2'b01, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MULN};
    vecs[1] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIVN};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DIVN};
    vecs[3] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIVN};
    vecs[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULN};
    vecs[5] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULN};
    vecs[6] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULN};
    vecs[7] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIVN};

    tick(); tick();
    reset = 1'b0;
    checkOutput("reset Busy", 32'(Busy), 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);

    // Table vectors: Busy length and committed HI/LO.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].vOp, vecs[i].vA, vecs[i].vB);
      A = ~vecs[i].vA; B = ~vecs[i].vB; op = ~vecs[i].vOp;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        checkOutput($sformatf("vec%0d busy c%0d", i, c), 32'(Busy), 32'd1);
        tick();
      end
      checkOutput($sformatf("vec%0d done Busy", i), 32'(Busy), 32'd0);
      checkOutput($sformatf("vec%0d HI", i), HI, vecs[i].expHi);
      checkOutput($sformatf("vec%0d LO", i), LO, vecs[i].expLo);
    end

    // mthi then a divide by zero: HI/LO stay as they were.
    HIWr = 1'b1; A = 32'h1234;
    tick();
    HIWr = 1'b0;
    checkOutput("mthi HI", HI, 32'h1234);
    applyStimulus(2'b10, 32'd5, 32'd0);
    for (int c = 0; c < DIVN; c++) begin
      checkOutput("div0 busy", 32'(Busy), 32'd1);
      tick();
    end
    checkOutput("div0 Busy", 32'(Busy), 32'd0);
    checkOutput("div0 HI", HI, 32'h1234);
    checkModel("div0");

    // Stall with MDReq held, then with MDReq low during Busy.
    MDReq = 1'b1; op = 2'b00; A = 32'd3; B = 32'd4; start = 1'b1;
    checkStall("stall start");
    checkOutput("stall start v", 32'(Stall), 32'd1);
    tick();
    start = 1'b0;
    for (int c = 0; c < MULN; c++) begin
      #1 checkOutput("stall busy", 32'(Stall), 32'd1);
      tick();
    end
    #1 checkOutput("stall after", 32'(Stall), 32'd0);
    MDReq = 1'b0;
    applyStimulus(2'b01, 32'd3, 32'd4);
    for (int c = 0; c < MULN; c++) begin
      #1 checkOutput("nostall busy", 32'(Stall), 32'd0);
      tick();
    end
    checkModel("stall seq");

    // Reset in the 3rd Busy cycle aborts without a later commit.
    applyStimulus(2'b00, 32'h00010000, 32'h00010000);
    tick(); tick();
    reset = 1'b1; MDReq = 1'b1;
    checkStall("reset stall");
    tick();
    reset = 1'b0; MDReq = 1'b0;
    checkOutput("abort Busy", 32'(Busy), 32'd0);
    checkOutput("abort HI", HI, 32'd0);
    checkOutput("abort LO", LO, 32'd0);
    for (int c = 0; c < 8; c++) tick();
    checkOutput("abort later HI", HI, 32'd0);
    checkOutput("abort later LO", LO, 32'd0);

    // A second start and an mtlo during Busy are both ignored.
    applyStimulus(2'b01, 32'hFFFFFFFE, 32'd3);
    tick();
    op = 2'b10; A = 32'd100; B = 32'd7; start = 1'b1; LOWr = 1'b1;
    tick();
    start = 1'b0; LOWr = 1'b0;
    tick(); tick();
    checkOutput("restart busy", 32'(Busy), 32'd1);
    tick();
    checkOutput("restart Busy", 32'(Busy), 32'd0);
    checkOutput("restart HI", HI, 32'hFFFFFFFF);
    checkOutput("restart LO", LO, 32'hFFFFFFFA);
    tick();
    checkOutput("restart still idle", 32'(Busy), 32'd0);

    // Random run against the model.
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(3) == 0);
      op    = 2'($urandom_range(3));
      A     = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      B     = ($urandom_range(7) == 0) ? 32'd0 :
              (($urandom_range(3) == 0) ? 32'($urandom_range(9)) : $urandom);
      HIWr  = ($urandom_range(3) == 0);
      LOWr  = ($urandom_range(3) == 0);
      MDReq = ($urandom_range(1) == 1);
      reset = ($urandom_range(60) == 0);
      checkStall("rand");
      tick();
      checkModel("rand");
    end
    reset = 1'b0; start = 1'b0; HIWr = 1'b0; LOWr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
